// File: rtl/instruction_queue_if.sv
// -----------------------------------------------------------------------------
// instruction_queue_if
//   Bundles the fetch-side push port, the decoder-side issue port and the ROB
//   flush of the instruction queue.
//   slave  : the queue's view (consumes fetch/stall/flush, drives head/count).
//   master : the environment's view (fetch unit, decoder, ROB).
//   Signals:
//     rob_rst              synchronous flush from the ROB
//     fetch_valid/_ready   push handshake
//     fetch_instruction, fetch_c_instruction, fetch_pc,
//     fetch_jalr_prediction, fetch_br_prediction   pushed entry fields
//     issue_stall          downstream cannot take an instruction
//     instruction_in       head entry is issued this cycle
//     instruction, c_instruction, pc, jalr_prediction, br_prediction  head
//     count                number of valid entries
// -----------------------------------------------------------------------------
interface instruction_queue_if #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
);
    logic             rob_rst;
    logic             fetch_valid;
    logic [31:0]      fetch_instruction;
    logic             fetch_c_instruction;
    logic [16:0]      fetch_pc;
    logic [16:0]      fetch_jalr_prediction;
    logic             fetch_br_prediction;
    logic             fetch_ready;
    logic             issue_stall;
    logic             instruction_in;
    logic [31:0]      instruction;
    logic             c_instruction;
    logic [16:0]      pc;
    logic [16:0]      jalr_prediction;
    logic             br_prediction;
    logic [PTR_W:0]   count;

    modport slave (
        input  rob_rst, fetch_valid, fetch_instruction, fetch_c_instruction,
               fetch_pc, fetch_jalr_prediction, fetch_br_prediction, issue_stall,
        output fetch_ready, instruction_in, instruction, c_instruction, pc,
               jalr_prediction, br_prediction, count
    );

    modport master (
        output rob_rst, fetch_valid, fetch_instruction, fetch_c_instruction,
               fetch_pc, fetch_jalr_prediction, fetch_br_prediction, issue_stall,
        input  fetch_ready, instruction_in, instruction, c_instruction, pc,
               jalr_prediction, br_prediction, count
    );
endinterface

// File: rtl/instruction_queue.sv
// -----------------------------------------------------------------------------
// instruction_queue
//   Circular buffer of fetched instructions between fetch and decode. Accepts
//   at most one push per cycle, presents the oldest entry combinationally and
//   issues it when downstream is not stalled. A ROB flush empties the queue.
//   Ports:
//     clk    clock, all state changes on posedge
//     rst_n  asynchronous active-low reset (pointers and count only)
//     iq     instruction_queue_if.slave (fetch push, decoder issue, flush)
// -----------------------------------------------------------------------------
module instruction_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_queue_if.slave  iq
);

    typedef struct packed {
        logic [31:0] instruction;
        logic        c_instruction;
        logic [16:0] pc;
        logic [16:0] jalr_prediction;
        logic        br_prediction;
    } entry_t;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;

    logic             fetch_ready;
    logic             push;
    logic             pop;
    entry_t           head_entry;

    // Readiness looks only at the registered count, so a full queue stays
    // closed to fetch even in a cycle where it also pops.
    assign fetch_ready = (count_q != FULL_COUNT);
    assign push        = iq.fetch_valid && fetch_ready && !iq.rob_rst;
    assign pop         = (count_q != '0) && !iq.issue_stall && !iq.rob_rst;

    // Empty queue presents all-zero head fields rather than stale memory.
    assign head_entry  = (count_q != '0) ? mem[head_q] : '0;

    assign iq.fetch_ready     = fetch_ready;
    assign iq.instruction_in  = pop;
    assign iq.instruction     = head_entry.instruction;
    assign iq.c_instruction   = head_entry.c_instruction;
    assign iq.pc              = head_entry.pc;
    assign iq.jalr_prediction = head_entry.jalr_prediction;
    assign iq.br_prediction   = head_entry.br_prediction;
    assign iq.count           = count_q;

    // NOTE: storage has no reset; entries are only ever read below count, so
    // clearing them would buy nothing and stop the array mapping to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= '{
                instruction:     iq.fetch_instruction,
                c_instruction:   iq.fetch_c_instruction,
                pc:              iq.fetch_pc,
                jalr_prediction: iq.fetch_jalr_prediction,
                br_prediction:   iq.fetch_br_prediction
            };
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    // Pointers wrap naturally because DEPTH is a power of two; full vs empty is
    // told apart by count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (iq.rob_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PTR_ONE;
            if (pop)  head_q <= head_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_queue
//   Scoreboard bench: the stimulus side records every accepted push in an
//   ordered queue; a monitor pops and compares whenever the DUT issues. A
//   separate checker compares count/fetch_ready/instruction_in and the empty
//   head against a reference entry count each cycle.
// -----------------------------------------------------------------------------
module tb_instruction_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic        c;
        logic [16:0] pc;
        logic [16:0] jalr;
        logic        br;
    } item_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instruction_queue_if #(.DEPTH(DEPTH)) iq ();

    instruction_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iq    (iq)
    );

    always #5 clk = ~clk;

    item_t exp_q[$];
    int    model_cnt = 0;
    int    checks    = 0;
    int    failures  = 0;
    int    issued    = 0;
    int    mark;
    item_t mon_item;
    bit    m_push;
    bit    m_pop;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic item_t rand_item();
        item_t it;
        it.instr = $urandom;
        it.c     = 1'($urandom_range(0, 1));
        it.pc    = 17'($urandom_range(0, 17'h1FFFF));
        it.jalr  = 17'($urandom_range(0, 17'h1FFFF));
        it.br    = 1'($urandom_range(0, 1));
        return it;
    endfunction

    // Drive one cycle of inputs (set just after an edge), then advance one clock.
    task automatic step(input bit v, input bit stall, input bit rob, input item_t it);
        iq.fetch_valid           = v;
        iq.issue_stall           = stall;
        iq.rob_rst               = rob;
        iq.fetch_instruction     = it.instr;
        iq.fetch_c_instruction   = it.c;
        iq.fetch_pc              = it.pc;
        iq.fetch_jalr_prediction = it.jalr;
        iq.fetch_br_prediction   = it.br;
        @(posedge clk);
        #1;
    endtask

    function automatic item_t pc_item(input logic [16:0] pc);
        item_t it;
        it      = rand_item();
        it.pc   = pc;
        return it;
    endfunction

    // Reference model: a FIFO with capacity DEPTH. Accepted pushes enter the
    // scoreboard at the edge; the monitor removes entries as they are issued.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            model_cnt = 0;
        end else if (iq.rob_rst) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            m_pop  = (model_cnt != 0) && !iq.issue_stall;
            m_push = iq.fetch_valid && (model_cnt != DEPTH);
            if (m_push)
                exp_q.push_back('{iq.fetch_instruction, iq.fetch_c_instruction,
                                  iq.fetch_pc, iq.fetch_jalr_prediction,
                                  iq.fetch_br_prediction});
            model_cnt = model_cnt + int'(m_push) - int'(m_pop);
        end
    end

    // Per-cycle control checks, away from the active edge.
    always @(negedge clk) begin
        check("count", 68'(iq.count), 68'(model_cnt));
        check("fetch_ready", 68'(iq.fetch_ready), 68'(model_cnt != DEPTH));
        check("instruction_in", 68'(iq.instruction_in),
              68'(rst_n && model_cnt != 0 && !iq.issue_stall && !iq.rob_rst));
        if (model_cnt == 0)
            check("empty_head", {iq.instruction, iq.c_instruction, iq.pc,
                                 iq.jalr_prediction, iq.br_prediction}, 68'd0);
    end

    // Scoreboard monitor: every issue must match the oldest accepted push.
    always @(negedge clk) begin
        if (iq.instruction_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 68'd1, 68'd0);
            end else begin
                mon_item = exp_q.pop_front();
                check("issued_entry", {iq.instruction, iq.c_instruction, iq.pc,
                                       iq.jalr_prediction, iq.br_prediction},
                      68'(mon_item));
                issued++;
            end
        end
    end

    initial begin
        item_t it;
        iq.fetch_valid           = 1'b0;
        iq.issue_stall           = 1'b0;
        iq.rob_rst               = 1'b0;
        iq.fetch_instruction     = '0;
        iq.fetch_c_instruction   = 1'b0;
        iq.fetch_pc              = '0;
        iq.fetch_jalr_prediction = '0;
        iq.fetch_br_prediction   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, '0);

        // Three back-to-back pushes issue in order and drain the queue.
        mark = issued;
        step(1, 0, 0, pc_item(17'h00));
        step(1, 0, 0, pc_item(17'h04));
        step(1, 0, 0, pc_item(17'h08));
        repeat (4) step(0, 0, 0, '0);
        check("t1_issued", 68'(issued - mark), 68'd3);
        check("t1_count", 68'(iq.count), 68'd0);

        // Fill under stall; the ninth push is dropped; then drain all eight.
        for (int i = 0; i < 9; i++) step(1, 1, 0, pc_item(17'(i * 4)));
        check("t2_full_count", 68'(iq.count), 68'(DEPTH));
        check("t2_full_ready", 68'(iq.fetch_ready), 68'd0);
        mark = issued;
        repeat (10) step(0, 0, 0, '0);
        check("t2_issued", 68'(issued - mark), 68'(DEPTH));

        // Full queue with pop and push together: push refused, then accepted.
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, rand_item());
        step(1, 0, 0, rand_item());
        check("t3_refused_count", 68'(iq.count), 68'(DEPTH - 1));
        step(1, 0, 0, rand_item());
        check("t3_accept_count", 68'(iq.count), 68'(DEPTH - 1));
        repeat (10) step(0, 0, 0, '0);

        // Twenty entries across pointer wrap with intermittent stall.
        mark = issued;
        for (int i = 0; i < 20; i++) begin
            it      = rand_item();
            it.jalr = 17'h1ABCD;
            step(1, (i % 3) == 0, 0, it);
        end
        repeat (10) step(0, 0, 0, '0);
        check("t4_issued", 68'(issued - mark), 68'd20);

        // Flush with five entries and a concurrent push; redirected push issues alone.
        for (int i = 0; i < 5; i++) step(1, 1, 0, rand_item());
        check("t5_pre_count", 68'(iq.count), 68'd5);
        step(1, 0, 1, rand_item());
        check("t5_flush_count", 68'(iq.count), 68'd0);
        check("t5_flush_ready", 68'(iq.fetch_ready), 68'd1);
        mark = issued;
        step(1, 0, 0, pc_item(17'h100));
        repeat (3) step(0, 0, 0, '0);
        check("t5_issued", 68'(issued - mark), 68'd1);

        // Asynchronous reset mid-cycle with three entries queued.
        for (int i = 0; i < 3; i++) step(1, 1, 0, rand_item());
        iq.fetch_valid = 1'b0;
        iq.issue_stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_count", 68'(iq.count), 68'd0);
        check("t6_rst_issue", 68'(iq.instruction_in), 68'd0);
        check("t6_rst_ready", 68'(iq.fetch_ready), 68'd1);
        check("t6_rst_head", {iq.instruction, iq.c_instruction, iq.pc,
                              iq.jalr_prediction, iq.br_prediction}, 68'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, '0);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 99) < 3, rand_item());
        repeat (DEPTH + 2) step(0, 0, 0, '0);
        check("final_drained", 68'(iq.count), 68'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
